// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register followed by the writeback stage.
// Holds the memory-stage results for one cycle, extracts and extends load data,
// selects the register-file write value, flags misaligned loads and keeps a
// retired-instruction counter. Every output is driven from registered state only.
module writeback_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int RET_CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] memory_bypass,
    input  logic [DATA_WIDTH-1:0] memory_output,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic [4:0]            rd_in,
    input  logic                  reg_write_in,
    input  logic [1:0]            wb_sel_in,
    input  logic [2:0]            funct3_in,
    output logic                  valid_out,
    output logic                  reg_write_out,
    output logic [4:0]            rd_out,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  misaligned_load,
    output logic [RET_CNT_W-1:0]  retired_count
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // A load is misaligned when a halfword sits on an odd byte or a word
    // (including the unlisted funct3 codes, which behave as LW) is not on a
    // 4-byte boundary. Byte loads can never be misaligned.
    function automatic logic isMisaligned(input logic [1:0] sel,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
        logic result;
        result = 1'b0;
        if (sel == SEL_LOAD) begin
            if (f3 == F3_LH || f3 == F3_LHU)
                result = off[0];
            else if (f3 != F3_LB && f3 != F3_LBU)
                result = (off != 2'b00);
        end
        return result;
    endfunction

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_word;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [4:0]            r_rd;
    logic                  r_regWrite;
    logic [1:0]            r_wbSel;
    logic [2:0]            r_funct3;
    logic [RET_CNT_W-1:0]  r_retired;

    logic                  w_capture;
    logic                  w_inMisaligned;
    logic                  w_misaligned;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_loadData;
    logic [DATA_WIDTH-1:0] w_writeData;

    assign w_capture      = ~flush & ~stall;
    assign w_inMisaligned = isMisaligned(wb_sel_in, funct3_in, memory_bypass[1:0]);
    assign w_misaligned   = r_valid & isMisaligned(r_wbSel, r_funct3, r_addr[1:0]);

    // MEM/WB register: flush inserts a bubble (beating stall), stall holds, otherwise capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_addr     <= '0;
            r_word     <= '0;
            r_pc       <= '0;
            r_rd       <= '0;
            r_regWrite <= 1'b0;
            r_wbSel    <= SEL_ALU;
            r_funct3   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_valid    <= valid_in;
            r_addr     <= memory_bypass;
            r_word     <= memory_output;
            r_pc       <= pc_in;
            r_rd       <= rd_in;
            r_regWrite <= reg_write_in;
            r_wbSel    <= wb_sel_in;
            r_funct3   <= funct3_in;
        end
    end

    // Retire counter advances once per captured valid, aligned instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_retired <= '0;
        else if (w_capture && valid_in && !w_inMisaligned)
            r_retired <= r_retired + 1'b1;
    end

    // Little-endian byte/half extraction and sign or zero extension.
    always_comb begin
        w_loadData = r_word;
        case (r_addr[1:0])
            2'd0:    w_byte = r_word[7:0];
            2'd1:    w_byte = r_word[15:8];
            2'd2:    w_byte = r_word[23:16];
            default: w_byte = r_word[31:24];
        endcase
        w_half = r_addr[1] ? r_word[31:16] : r_word[15:0];
        case (r_funct3)
            F3_LB:   w_loadData = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  w_loadData = {24'd0, w_byte};
            F3_LH:   w_loadData = {{16{w_half[15]}}, w_half};
            F3_LHU:  w_loadData = {16'd0, w_half};
            default: w_loadData = r_word;
        endcase
    end

    // Register-file write value; the unused select code falls back to the ALU result.
    always_comb begin
        w_writeData = r_addr;
        case (r_wbSel)
            SEL_LOAD: w_writeData = w_loadData;
            SEL_PC4:  w_writeData = r_pc + 32'd4;
            default:  w_writeData = r_addr;
        endcase
    end

    assign valid_out       = r_valid;
    assign rd_out          = r_rd;
    assign write_data      = w_writeData;
    assign misaligned_load = w_misaligned;
    assign reg_write_out   = r_valid & r_regWrite & (r_rd != 5'd0) & ~w_misaligned;
    assign retired_count   = r_retired;

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors for writeback_stage. Stimulus pushes the
// hand-computed writeback result into a queue; a monitor on the falling edge
// pops and compares whenever the DUT presents a valid WB slot.
module tb_writeback_stage;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
    } expect_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        valid_in;
    logic [31:0] memory_bypass;
    logic [31:0] memory_output;
    logic [31:0] pc_in;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic [1:0]  wb_sel_in;
    logic [2:0]  funct3_in;
    logic        valid_out;
    logic        reg_write_out;
    logic [4:0]  rd_out;
    logic [31:0] write_data;
    logic        misaligned_load;
    logic [31:0] retired_count;

    expect_t     scoreboard[$];
    int          nVectors    = 0;
    int          nMiscompares = 0;
    int          expRetired  = 0;

    localparam logic [31:0] WORD = 32'h80706050;

    writeback_stage #(.DATA_WIDTH(32), .RET_CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .valid_in        (valid_in),
        .memory_bypass   (memory_bypass),
        .memory_output   (memory_output),
        .pc_in           (pc_in),
        .rd_in           (rd_in),
        .reg_write_in    (reg_write_in),
        .wb_sel_in       (wb_sel_in),
        .funct3_in       (funct3_in),
        .valid_out       (valid_out),
        .reg_write_out   (reg_write_out),
        .rd_out          (rd_out),
        .write_data      (write_data),
        .misaligned_load (misaligned_load),
        .retired_count   (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge and check the retire counter model.
    task automatic tick(input string name);
        @(posedge clk);
        #1;
        checkOutput({name, " retired"}, 64'(retired_count), 64'(expRetired));
    endtask

    task automatic applyStimulus(input string name, input logic [31:0] addr,
                                 input logic [31:0] pc, input logic [4:0] rd,
                                 input logic rw, input logic [1:0] sel,
                                 input logic [2:0] f3, input logic [31:0] expData,
                                 input logic expRw, input logic expMis);
        expect_t e;
        valid_in      = 1'b1;
        memory_bypass = addr;
        memory_output = WORD;
        pc_in         = pc;
        rd_in         = rd;
        reg_write_in  = rw;
        wb_sel_in     = sel;
        funct3_in     = f3;
        e.name = name; e.data = expData; e.rd = rd; e.rw = expRw; e.mis = expMis;
        scoreboard.push_back(e);
        if (!expMis) expRetired++;
        tick(name);
        valid_in = 1'b0;
    endtask

    // Monitor: compare every presented WB slot against the oldest expected entry.
    always @(negedge clk) begin
        expect_t e;
        if (rst && valid_out) begin
            if (scoreboard.size() == 0) begin
                checkOutput("unexpected valid_out", 64'(valid_out), 64'd0);
            end else begin
                e = scoreboard.pop_front();
                checkOutput(e.name, {25'd0, misaligned_load, reg_write_out, rd_out, write_data},
                            {25'd0, e.mis, e.rw, e.rd, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        expect_t held;
        rst = 1'b0; stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
        memory_bypass = '0; memory_output = '0; pc_in = '0; rd_in = '0;
        reg_write_in = 1'b0; wb_sel_in = 2'b00; funct3_in = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset state",
                    {valid_out, reg_write_out, misaligned_load, rd_out, write_data, retired_count},
                    64'd0);
        rst = 1'b1;
        tick("after reset");

        // Loads from word 0x80706050
        applyStimulus("LB 0x101",   32'h101, 0, 5'd5,  1, 2'b01, 3'b000, 32'h00000060, 1, 0);
        applyStimulus("LB 0x103",   32'h103, 0, 5'd6,  1, 2'b01, 3'b000, 32'hFFFFFF80, 1, 0);
        applyStimulus("LHU 0x102",  32'h102, 0, 5'd7,  1, 2'b01, 3'b101, 32'h00008070, 1, 0);
        applyStimulus("LH 0x102",   32'h102, 0, 5'd8,  1, 2'b01, 3'b001, 32'hFFFF8070, 1, 0);
        applyStimulus("LBU 0x103",  32'h103, 0, 5'd9,  1, 2'b01, 3'b100, 32'h00000080, 1, 0);
        applyStimulus("LW 0x100",   32'h100, 0, 5'd10, 1, 2'b01, 3'b010, 32'h80706050, 1, 0);
        applyStimulus("f3=011",     32'h100, 0, 5'd11, 1, 2'b01, 3'b011, 32'h80706050, 1, 0);
        // Misaligned loads: no write, counter unchanged
        applyStimulus("LW 0x102 mis",  32'h102, 0, 5'd12, 1, 2'b01, 3'b010, 32'h80706050, 0, 1);
        applyStimulus("LH 0x101 mis",  32'h101, 0, 5'd13, 1, 2'b01, 3'b001, 32'h00006050, 0, 1);
        applyStimulus("LHU 0x103 mis", 32'h103, 0, 5'd13, 1, 2'b01, 3'b101, 32'h00008070, 0, 1);
        // ALU and pc+4 paths
        applyStimulus("ALU",        32'hDEADBEEF, 0, 5'd14, 1, 2'b00, 3'b000, 32'hDEADBEEF, 1, 0);
        applyStimulus("sel=11",     32'h12345678, 0, 5'd15, 1, 2'b11, 3'b000, 32'h12345678, 1, 0);
        applyStimulus("PC4 rd1",    32'h0, 32'h100, 5'd1, 1, 2'b10, 3'b000, 32'h00000104, 1, 0);
        applyStimulus("PC4 rd0",    32'h0, 32'h100, 5'd0, 1, 2'b10, 3'b000, 32'h00000104, 0, 0);
        applyStimulus("PC4 wrap",   32'h0, 32'hFFFFFFFC, 5'd2, 1, 2'b10, 3'b000, 32'h0, 1, 0);
        applyStimulus("ALU no rw",  32'h5, 0, 5'd3, 0, 2'b00, 3'b000, 32'h5, 0, 0);
        applyStimulus("ALU odd adr",32'h103, 0, 5'd4, 1, 2'b00, 3'b010, 32'h103, 1, 0);
        tick("bubble");

        // Stall: held slot is presented again each cycle, new inputs ignored
        applyStimulus("pre-stall",  32'hA5A5, 0, 5'd20, 1, 2'b00, 3'b000, 32'hA5A5, 1, 0);
        held = scoreboard[scoreboard.size() - 1];
        stall = 1'b1; valid_in = 1'b1; memory_bypass = 32'h1111; rd_in = 5'd21;
        for (int i = 0; i < 3; i++) begin
            scoreboard.push_back(held);
            tick("stall");
        end
        flush = 1'b1;
        tick("stall+flush");
        checkOutput("flush valid_out", 64'(valid_out), 64'd0);
        stall = 1'b0; flush = 1'b0; valid_in = 1'b0;

        // Reset dropped between edges while a valid write is in WB
        applyStimulus("pre-reset",  32'h77, 0, 5'd22, 1, 2'b00, 3'b000, 32'h77, 1, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("async reset",
                    {valid_out, reg_write_out, misaligned_load, rd_out, write_data, retired_count},
                    64'd0);
        expRetired = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus("post-reset ALU", 32'(i + 1), 0, 5'(i + 1), 1, 2'b00, 3'b000,
                          32'(i + 1), 1, 0);
        checkOutput("retired after 4", 64'(retired_count), 64'd4);
        tick("drain");
        tick("drain");
        checkOutput("scoreboard empty", 64'(scoreboard.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
